// File: rtl/sprite_pack_writer_pkg.sv
// rtl/sprite_pack_writer_pkg.sv - shared sprite pixel types, palette and packing constants
package sprite_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [3:0]  pal_idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } wr_state_t;

  localparam int PIX_PER_WORD = 8;
  localparam int PAL_SIZE     = 16;

  // Entry 0 sits in the least significant slot, entry 15 in the most significant.
  localparam logic [PAL_SIZE-1:0][11:0] PALETTE = {
    12'h433, 12'h667, 12'h34C, 12'h800,
    12'hB55, 12'h003, 12'h79B, 12'hE12,
    12'h007, 12'h743, 12'h000, 12'h511,
    12'hEA7, 12'h986, 12'h211, 12'hFFE
  };

endpackage

// File: rtl/sprite_pack_writer_if.sv
// rtl/sprite_pack_writer_if.sv - pixel stream in and BRAM write port out of the sprite writer
interface sprite_pack_writer_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 6
) ();

  rgb444_t             pix_rgb;
  logic                pix_valid;
  logic                pix_ready;
  logic                bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [31:0]         bram_wdata;

  // The writer accepts pixels and masters the BRAM write port.
  modport master (
    input  pix_rgb,
    input  pix_valid,
    output pix_ready,
    output bram_we,
    output bram_addr,
    output bram_wdata
  );

  // The loader/BRAM side of the same bundle.
  modport slave (
    output pix_rgb,
    output pix_valid,
    input  pix_ready,
    input  bram_we,
    input  bram_addr,
    input  bram_wdata
  );

endinterface

// File: rtl/sprite_pack_writer_rgb_to_pal_idx.sv
// rtl/sprite_pack_writer_rgb_to_pal_idx.sv - exact-match RGB444 to palette index encoder
module rgb_to_pal_idx
  import sprite_pkg::*;
(
  input  rgb444_t  rgb_i,
  output pal_idx_t idx_o,
  output logic     hit_o
);

  // Scan from the top entry down so the lowest matching index is the last one written.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = PAL_SIZE - 1; i >= 0; i--) begin
      if (rgb_i == PALETTE[i]) begin
        idx_o = pal_idx_t'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_pack_writer.sv
// rtl/sprite_pack_writer.sv - packs 4-bpp palette indices into 32-bit sprite BRAM words; SPRITE_WR_MISS_CNT_EN adds miss_count
module sprite_pack_writer
  import sprite_pkg::*;
#(
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 20,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int MISS_IDX  = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  sprite_pack_writer_if.master  bus,
  output logic                  busy,
  output logic                  done
`ifdef SPRITE_WR_MISS_CNT_EN
  ,
  output logic [9:0]            miss_count
`endif
);

  localparam int NPIX  = SPR_W * SPR_H;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [2:0]        LAST_NIB = 3'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam pal_idx_t          MISS     = pal_idx_t'(MISS_IDX);

  wr_state_t         state_q;
  logic [CNT_W-1:0]  pix_cnt_q;
  logic [2:0]        nib_cnt_q;
  logic [31:0]       pack_q;
  logic [31:0]       pack_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;

  pal_idx_t          enc_idx;
  logic              enc_hit;
  pal_idx_t          pix_idx;
  logic              accept;
  logic              last_pix;

  rgb_to_pal_idx u_enc (
    .rgb_i (bus.pix_rgb),
    .idx_o (enc_idx),
    .hit_o (enc_hit)
  );

  assign pix_idx  = enc_hit ? enc_idx : MISS;
  assign accept   = bus.pix_valid && (state_q == S_LOAD);
  assign last_pix = (pix_cnt_q == LAST_PIX);

  // Pack register with the incoming index merged into the current nibble slot.
  always_comb begin
    pack_d = pack_q;
    pack_d[{nib_cnt_q, 2'b00} +: 4] = pix_idx;
  end

  // Load sequencer: counts pixels, emits one registered write per full or final word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      nib_cnt_q <= '0;
      pack_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (we_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD;
            pix_cnt_q <= '0;
            nib_cnt_q <= '0;
            pack_q    <= '0;
            addr_q    <= BASE;
          end
        end
        S_LOAD: begin
          if (accept) begin
            pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            nib_cnt_q <= nib_cnt_q + 3'd1;
            // A completed or final word leaves through wdata; the pack register restarts empty.
            if (nib_cnt_q == LAST_NIB || last_pix) begin
              we_q    <= 1'b1;
              wdata_q <= pack_d;
              pack_q  <= '0;
            end else begin
              pack_q  <= pack_d;
            end
            if (last_pix) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_ready  = (state_q == S_LOAD);
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign busy           = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done           = done_q;

`ifdef SPRITE_WR_MISS_CNT_EN
  logic [9:0] miss_q;

  // Saturating count of accepted pixels with no palette match, cleared per load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      miss_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      miss_q <= '0;
    end else if (accept && !enc_hit && miss_q != 10'h3FF) begin
      miss_q <= miss_q + 10'd1;
    end
  end

  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_sprite_pack_writer.sv
// tb/tb_sprite_pack_writer.sv - randomized self-checking bench for sprite_pack_writer against a pixel-level model
module tb_sprite_pack_writer;

  localparam int BW = 20, BH = 20, BN = BW * BH;
  localparam int SW = 3,  SH = 3,  SN = SW * SH;
  localparam int B_MISS = 0, S_MISS = 9;

  int errors = 0;
  int checks = 0;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_b, start_b, busy_b, done_b;
  logic rst_s, start_s, busy_s, done_s;
  bit   small_fin = 1'b0;

  sprite_pack_writer_if #(.ADDR_W(6)) bus_b ();
  sprite_pack_writer_if #(.ADDR_W(6)) bus_s ();

`ifdef SPRITE_WR_MISS_CNT_EN
  logic [9:0] miss_b, miss_s;
`endif

  sprite_pack_writer #(.SPR_W(BW), .SPR_H(BH), .ADDR_W(6), .BASE_ADDR(0), .MISS_IDX(B_MISS)) dut_b (
    .Clk(Clk), .Reset(rst_b), .start(start_b), .bus(bus_b), .busy(busy_b), .done(done_b)
`ifdef SPRITE_WR_MISS_CNT_EN
    , .miss_count(miss_b)
`endif
  );

  sprite_pack_writer #(.SPR_W(SW), .SPR_H(SH), .ADDR_W(6), .BASE_ADDR(0), .MISS_IDX(S_MISS)) dut_s (
    .Clk(Clk), .Reset(rst_s), .start(start_s), .bus(bus_s), .busy(busy_s), .done(done_s)
`ifdef SPRITE_WR_MISS_CNT_EN
    , .miss_count(miss_s)
`endif
  );

  logic [11:0] pal_tb [16] = '{12'hFFE, 12'h211, 12'h986, 12'hEA7, 12'h511, 12'h000, 12'h743, 12'h007,
                               12'hE12, 12'h79B, 12'h003, 12'hB55, 12'h800, 12'h34C, 12'h667, 12'h433};

  typedef struct {
    bit          rst_seen;
    bit          active;
    int          tail;
    int          cnt;
    int          miss;
    logic [31:0] word;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    bit          done;
    bit          busy;
    bit          ready;
  } model_t;

  model_t m_b, m_s;

  logic [31:0] wd_b[$], wd_s[$];
  int          wa_b[$], wa_s[$];
  int          done_cnt_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void enc(input logic [11:0] rgb, input int miss_idx, output logic [3:0] ix, output bit hit);
    hit = 1'b0;
    ix  = 4'(miss_idx);
    for (int i = 0; i < 16; i++) begin
      if (!hit && rgb == pal_tb[i]) begin
        hit = 1'b1;
        ix  = 4'(i);
      end
    end
  endfunction

  // Pixel p goes to word p/8, nibble p%8; a word is due the cycle after its 8th pixel or the last one.
  task automatic step(inout model_t m, input int npix, input int miss_idx,
                      input logic rst, input logic st, input logic vld, input logic [11:0] rgb);
    bit          was_idle, hit;
    logic [3:0]  ix;
    if (rst) begin
      m.rst_seen = 1'b1; m.active = 1'b0; m.tail = 0; m.cnt = 0; m.miss = 0; m.word = '0;
      m.we = 1'b0; m.addr = 0; m.wdata = '0; m.done = 1'b0; m.busy = 1'b0; m.ready = 1'b0;
      return;
    end
    was_idle = !m.active && m.tail == 0;
    m.we   = 1'b0;
    m.done = 1'b0;
    if (m.tail == 1) begin
      m.done = 1'b1;
      m.tail = 2;
    end else if (m.tail == 2) begin
      m.tail = 0;
    end
    if (was_idle && st === 1'b1) begin
      m.active = 1'b1; m.cnt = 0; m.word = '0; m.miss = 0;
    end else if (m.active && vld === 1'b1) begin
      enc(rgb, miss_idx, ix, hit);
      if (!hit && m.miss < 1023) m.miss++;
      m.word[4 * (m.cnt % 8) +: 4] = ix;
      m.cnt++;
      if (m.cnt % 8 == 0 || m.cnt == npix) begin
        m.we    = 1'b1;
        m.wdata = m.word;
        m.addr  = (m.cnt - 1) / 8;
        m.word  = '0;
      end
      if (m.cnt == npix) begin
        m.active = 1'b0;
        m.tail   = 1;
      end
    end
    m.ready = m.active;
    m.busy  = m.active || m.tail == 1;
  endtask

  always @(posedge Clk) begin
    step(m_b, BN, B_MISS, rst_b, start_b, bus_b.pix_valid, bus_b.pix_rgb);
    step(m_s, SN, S_MISS, rst_s, start_s, bus_s.pix_valid, bus_s.pix_rgb);
  end

  task automatic cmp(input string t, input model_t m, input logic rdy, input logic we, input logic [5:0] addr,
                     input logic [31:0] wd, input logic bsy, input logic dn);
    chk({t, ".ready"}, 32'(rdy), 32'(m.ready));
    chk({t, ".we"},    32'(we),  32'(m.we));
    chk({t, ".busy"},  32'(bsy), 32'(m.busy));
    chk({t, ".done"},  32'(dn),  32'(m.done));
    if (m.we) begin
      chk({t, ".addr"},  32'(addr), 32'(m.addr));
      chk({t, ".wdata"}, wd, m.wdata);
    end
  endtask

  // Compare both DUTs against the model mid-cycle and log every write.
  always @(negedge Clk) begin
    if (m_b.rst_seen) begin
      cmp("big", m_b, bus_b.pix_ready, bus_b.bram_we, bus_b.bram_addr, bus_b.bram_wdata, busy_b, done_b);
`ifdef SPRITE_WR_MISS_CNT_EN
      chk("big.miss", 32'(miss_b), 32'(m_b.miss));
`endif
    end
    if (m_s.rst_seen) begin
      cmp("small", m_s, bus_s.pix_ready, bus_s.bram_we, bus_s.bram_addr, bus_s.bram_wdata, busy_s, done_s);
`ifdef SPRITE_WR_MISS_CNT_EN
      chk("small.miss", 32'(miss_s), 32'(m_s.miss));
`endif
    end
    if (bus_b.bram_we === 1'b1) begin
      wd_b.push_back(bus_b.bram_wdata);
      wa_b.push_back(int'(bus_b.bram_addr));
    end
    if (bus_s.bram_we === 1'b1) begin
      wd_s.push_back(bus_s.bram_wdata);
      wa_s.push_back(int'(bus_s.bram_addr));
    end
    if (done_b === 1'b1) done_cnt_b++;
  end

  function automatic logic [11:0] color(input int mode, input int p);
    case (mode)
      0:       return 12'hE12;
      1:       return 12'h433;
      2:       return ($urandom_range(4) == 0) ? 12'($urandom) : pal_tb[$urandom_range(15)];
      3:       return (p == 0) ? 12'h123 : pal_tb[$urandom_range(15)];
      default: return (p % 11 == 5) ? 12'h123 : pal_tb[(p * 7 + 3) % 16];
    endcase
  endfunction

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(posedge Clk); #1;
    start_b = 1'b0;
  endtask

  task automatic feed_b(input int from, input int mode, input int gap, input int abort_at);
    int sent = from;
    while (sent < BN) begin
      if (abort_at >= 0 && sent == abort_at) begin
        bus_b.pix_valid = 1'b0;
        start_b = 1'b0;
        rst_b = 1'b1;
        @(posedge Clk); #1;
        rst_b = 1'b0;
        return;
      end
      bus_b.pix_valid = ($urandom_range(99) >= gap);
      bus_b.pix_rgb   = bus_b.pix_valid ? color(mode, sent) : 12'($urandom);
      start_b = (mode == 2) && ($urandom_range(31) == 0);
      @(posedge Clk); #1;
      if (bus_b.pix_valid) sent++;
    end
    bus_b.pix_valid = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done_b(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (done_b === 1'b1) found = 1'b1;
      else begin @(posedge Clk); #1; end
    end
    chk({nm, ".done_seen"}, 32'(found), 32'd1);
    @(posedge Clk); #1;
  endtask

  // Small 3x3 instance: partial final word and a random load.
  initial begin
    bit found;
    int sent, guard;
    rst_s = 1'b1; start_s = 1'b0; bus_s.pix_valid = 1'b0; bus_s.pix_rgb = '0;
    repeat (3) @(posedge Clk);
    #1 rst_s = 1'b0;
    wd_s.delete(); wa_s.delete();
    start_s = 1'b1; @(posedge Clk); #1; start_s = 1'b0;
    for (int k = 0; k < SN; k++) begin
      bus_s.pix_valid = 1'b1; bus_s.pix_rgb = 12'h433;
      @(posedge Clk); #1;
    end
    bus_s.pix_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (done_s === 1'b1) found = 1'b1;
      else begin @(posedge Clk); #1; end
    end
    chk("s433.done_seen", 32'(found), 32'd1);
    chk("s433.nwrites", 32'(wd_s.size()), 32'd2);
    if (wd_s.size() == 2) begin
      chk("s433.w0", wd_s[0], 32'hFFFFFFFF);
      chk("s433.a0", 32'(wa_s[0]), 32'd0);
      chk("s433.w1", wd_s[1], 32'h0000000F);
      chk("s433.a1", 32'(wa_s[1]), 32'd1);
    end
    repeat (2) @(posedge Clk); #1;
    for (int r = 0; r < 3; r++) begin
      start_s = 1'b1; @(posedge Clk); #1; start_s = 1'b0;
      sent = 0; guard = 0;
      while (sent < SN && guard < 300) begin
        bus_s.pix_valid = 1'($urandom_range(1));
        bus_s.pix_rgb   = color(2, sent);
        @(posedge Clk); #1;
        if (bus_s.pix_valid) sent++;
        guard++;
      end
      bus_s.pix_valid = 1'b0;
      repeat (4) @(posedge Clk); #1;
    end
    small_fin = 1'b1;
  end

  // Main 20x20 sequence and summary.
  initial begin
    logic [31:0] ref_w[$];
    logic [31:0] w0;
    int bad;
    rst_b = 1'b1; start_b = 1'b0; bus_b.pix_valid = 1'b0; bus_b.pix_rgb = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.ready", 32'(bus_b.pix_ready), 32'd0);
    chk("rst.we",    32'(bus_b.bram_we),   32'd0);
    chk("rst.busy",  32'(busy_b),          32'd0);
    chk("rst.done",  32'(done_b),          32'd0);
    chk("rst.addr",  32'(bus_b.bram_addr), 32'd0);
    chk("rst.wdata", bus_b.bram_wdata,     32'd0);
    rst_b = 1'b0;

    // First eight palette entries back to back.
    pulse_start_b();
    for (int k = 0; k < 8; k++) begin
      bus_b.pix_valid = 1'b1;
      bus_b.pix_rgb   = pal_tb[k];
      if (k == 7) chk("t1.we_early", 32'(bus_b.bram_we), 32'd0);
      @(posedge Clk); #1;
    end
    chk("t1.we",    32'(bus_b.bram_we),   32'd1);
    chk("t1.addr",  32'(bus_b.bram_addr), 32'd0);
    chk("t1.wdata", bus_b.bram_wdata,     32'h76543210);
    feed_b(8, 2, 30, -1);
    wait_done_b("t1");

    // Whole sprite of E12 without gaps.
    wd_b.delete(); wa_b.delete(); done_cnt_b = 0;
    pulse_start_b();
    feed_b(0, 0, 0, -1);
    chk("e12.flush_we",    32'(bus_b.bram_we),   32'd1);
    chk("e12.flush_busy",  32'(busy_b),          32'd1);
    chk("e12.flush_ready", 32'(bus_b.pix_ready), 32'd0);
    chk("e12.flush_addr",  32'(bus_b.bram_addr), 32'd49);
    @(posedge Clk); #1;
    chk("e12.done",   32'(done_b),        32'd1);
    chk("e12.busy",   32'(busy_b),        32'd0);
    chk("e12.we_off", 32'(bus_b.bram_we), 32'd0);
    repeat (3) @(posedge Clk); #1;
    chk("e12.nwrites", 32'(wd_b.size()), 32'd50);
    bad = 0;
    foreach (wd_b[i]) if (wd_b[i] !== 32'h88888888 || wa_b[i] != i) bad++;
    chk("e12.bad_words", 32'(bad), 32'd0);
    chk("e12.done_pulses", 32'(done_cnt_b), 32'd1);

    // Same deterministic pixels gap-free and with random gaps must give identical words.
    wd_b.delete(); wa_b.delete();
    pulse_start_b(); feed_b(0, 4, 0, -1); wait_done_b("gap0");
    ref_w = wd_b;
    wd_b.delete(); wa_b.delete();
    pulse_start_b(); feed_b(0, 4, 50, -1); wait_done_b("gap50");
    chk("gap.nwrites", 32'(wd_b.size()), 32'(ref_w.size()));
    bad = 0;
    foreach (ref_w[i]) if (i < wd_b.size() && wd_b[i] !== ref_w[i]) bad++;
    chk("gap.words_differ", 32'(bad), 32'd0);

    // Unmatched colour in pixel 0 maps to index 0.
    wd_b.delete(); wa_b.delete();
    pulse_start_b();
    bus_b.pix_valid = 1'b1; bus_b.pix_rgb = 12'h123;
    @(posedge Clk); #1;
`ifdef SPRITE_WR_MISS_CNT_EN
    chk("miss.one", 32'(miss_b), 32'd1);
`endif
    feed_b(1, 3, 20, -1);
    wait_done_b("miss");
    w0 = (wd_b.size() > 0) ? wd_b[0] : 32'hFFFFFFFF;
    chk("miss.nib0", 32'(w0[3:0]), 32'd0);
`ifdef SPRITE_WR_MISS_CNT_EN
    chk("miss.hold", 32'(miss_b), 32'd1);
    pulse_start_b();
    chk("miss.cleared", 32'(miss_b), 32'd0);
    feed_b(0, 0, 0, -1);
    wait_done_b("miss2");
`endif

    // Reset after 13 accepted pixels, then a fresh load.
    pulse_start_b();
    feed_b(0, 2, 20, 13);
    chk("abort.ready", 32'(bus_b.pix_ready), 32'd0);
    chk("abort.we",    32'(bus_b.bram_we),   32'd0);
    chk("abort.busy",  32'(busy_b),          32'd0);
    repeat (4) @(posedge Clk); #1;
    wd_b.delete(); wa_b.delete();
    pulse_start_b();
    feed_b(0, 2, 30, -1);
    wait_done_b("reload");
    chk("reload.a0", 32'((wa_b.size() > 0) ? wa_b[0] : -1), 32'd0);
    chk("reload.nwrites", 32'(wd_b.size()), 32'd50);

    for (int i = 0; i < 2000 && !small_fin; i++) @(posedge Clk);
    chk("small.finished", 32'(small_fin), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
